boot_memn: RTL
==============

# boot_memn

Parametrised successor to the fixed 32-bit boot memory. It holds the boot image loaded over a streaming valid/ready port and keeps a running modular checksum of the loaded words. At end of load it checks the sum against an expected value, then serves single-cycle-latency reads only once the image is verified. It sits between the external boot loader and the core's instruction-fetch path, and keeps the codebase's standard DFT scan hooks.

## Interface
- DATA_W, 32, word width in bits (8..64)
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W words
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs clear while low
- load_start  in  1  one-cycle pulse; clears pointer and checksum, enters LOAD
- load_valid  in  1  load word present
- load_data  in  DATA_W  load word
- load_last  in  1  qualifies final word of image
- load_ready  out  1  word accepted when load_valid && load_ready
- exp_sum  in  DATA_W  expected checksum, sampled in CHECK
- rd_req  in  1  read request; honoured only when rd_ready
- rd_addr  in  ADDR_W  read address
- rd_ready  out  1  high only in READY
- rd_valid  out  1  one cycle after an honoured rd_req
- rd_data  out  DATA_W  read word, valid with rd_valid
- boot_ok  out  1  image verified (state READY)
- boot_err  out  1  checksum mismatch or overflow (state ERROR)
- overflow  out  1  sticky; set on overflow, cleared by load_start or reset
- word_count  out  ADDR_W+1  words accepted in current load
- scan_in0..scan_in4, scan_enable, test_mode  in  1 each  DFT hooks; no functional effect
- scan_out0..scan_out4  out  1 each  DFT hooks; driven 0 pre-stitch

## Operation
- States: IDLE, LOAD, CHECK, READY, ERROR. Reset enters IDLE.
- In any state, load_start goes to LOAD on the next edge. It clears wr_ptr, sum, word_count and overflow. It has priority over every other event in that cycle, including a concurrent load handshake.
- LOAD: load_ready = 1. On each accept:
  - mem[wr_ptr] <= load_data
  - sum <= (sum + load_data) mod 2**DATA_W
  - wr_ptr and word_count increment
- Accept with load_last goes to CHECK. Same-cycle word is included in sum.
- Accept at wr_ptr = DEPTH-1 without load_last: word is stored and summed, overflow is set, state goes to ERROR.
- CHECK: one cycle. sum == exp_sum goes to READY, otherwise ERROR.
- READY: rd_ready = 1, boot_ok = 1. Memory is write-protected.
- ERROR: boot_err = 1. Only load_start or reset leaves ERROR.
- IDLE: load_ready = 0, rd_ready = 0.
- rd_req while !rd_ready is ignored. No rd_valid is produced.
- Memory array is not reset. Contents survive reset and load_start until overwritten.

## Timing
- Reset values: load_ready, rd_ready, rd_valid, boot_ok, boot_err, overflow, scan_out* = 0; rd_data = 0; word_count = 0.
- Load throughput: one word per cycle; load_ready is combinational from state only.
- Verdict latency: boot_ok or boot_err asserts 2 cycles after the last-word accept edge (edge 1 to CHECK, edge 2 to verdict).
- Read latency: 1. rd_valid and rd_data are registered. Back-to-back reads give one result per cycle.
- rd_data holds its last value when rd_valid = 0.
- load_start in READY with a same-cycle rd_req: the read is honoured (rd_ready was high). rd_valid fires next cycle while the state is already LOAD.
- Reset asserted mid-load: IDLE immediately (asynchronous). A partial image is never marked valid.

## Structure
- Package boot_mem_pkg holds:
  - state enum (IDLE, LOAD, CHECK, READY, ERROR)
  - default DATA_W and ADDR_W constants
- Sub-module boot_mem_array holds storage:
  - DEPTH x DATA_W register array, no reset
  - synchronous write port, registered read port, one write and one read port
- Top boot_memn holds the FSM, pointer, checksum, flags and DFT hooks.

## Test plan
- Load 1,2,3,4 with last on word 4 and exp_sum = 10 -> boot_ok = 1 at edge+2, word_count = 4. Then rd_addr = 2 -> rd_data = 3 one cycle later.
- Same load with exp_sum = 11 -> boot_err = 1, overflow = 0, rd_ready stays 0, rd_req gives no rd_valid.
- Load 16 words of 0xFFFFFFFF with no last (ADDR_W = 4) -> overflow = 1 and boot_err = 1 after word 16. Then load_start clears overflow and word_count.
- Load 0x80000000 and 0x80000001 with exp_sum = 1 -> wrap-around sum matches, boot_ok = 1.
- Drop reset mid-load after 3 words -> all outputs 0 at once. Reload 1 word 0x5 with exp_sum = 5 -> boot_ok = 1.
- load_start in the same cycle as a load_last accept -> state LOAD, word_count = 0, no CHECK cycle occurs.

Source files
------------

// File: rtl/boot_mem_pkg.sv
// Shared types and default geometry for the parametrised boot memory.
package boot_mem_pkg;

  localparam int DefaultDataW = 32;
  localparam int DefaultAddrW = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    READY,
    ERROR
  } state_e;

endpackage

// File: rtl/boot_memn_if.sv
// Load stream, read port and status bundle between the boot loader/fetch side and the boot memory.
interface boot_memn_if
  import boot_mem_pkg::*;
#(
  parameter int DATA_W = DefaultDataW,
  parameter int ADDR_W = DefaultAddrW
);

  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic [DATA_W-1:0] exp_sum;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ready;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              boot_ok;
  logic              boot_err;
  logic              overflow;
  logic [ADDR_W:0]   word_count;

  modport master (
    output load_start, load_valid, load_data, load_last, exp_sum, rd_req, rd_addr,
    input  load_ready, rd_ready, rd_valid, rd_data, boot_ok, boot_err, overflow, word_count
  );

  modport slave (
    input  load_start, load_valid, load_data, load_last, exp_sum, rd_req, rd_addr,
    output load_ready, rd_ready, rd_valid, rd_data, boot_ok, boot_err, overflow, word_count
  );

endinterface

// File: rtl/boot_mem_array.sv
// Boot image storage: unreset register array, one synchronous write port, one registered read port.
module boot_mem_array
  import boot_mem_pkg::*;
#(
  parameter int DATA_W = DefaultDataW,
  parameter int ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData_q
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  // Contents must survive reset so a retained image is still readable after a reload.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem_q[wrAddr] <= wrData;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdData_q <= '0;
    end else if (rdEn) begin
      rdData_q <= mem_q[rdAddr];
    end
  end

endmodule

// File: rtl/boot_memn.sv
// Boot memory top: load FSM with running checksum, verify-before-read gating, and DFT hooks.
module boot_memn
  import boot_mem_pkg::*;
#(
  parameter int DATA_W = DefaultDataW,
  parameter int ADDR_W = DefaultAddrW
) (
  input  logic        clk,
  input  logic        reset,
  boot_memn_if.slave  bus,
  input  logic        scan_in0,
  input  logic        scan_in1,
  input  logic        scan_in2,
  input  logic        scan_in3,
  input  logic        scan_in4,
  input  logic        scan_enable,
  input  logic        test_mode,
  output logic        scan_out0,
  output logic        scan_out1,
  output logic        scan_out2,
  output logic        scan_out3,
  output logic        scan_out4
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [ADDR_W:0]   wordCount_q, wordCount_d;
  logic              overflow_q, overflow_d;
  logic              rdValid_q;
  logic              accept;
  logic              rdFire;
  logic              unusedDft;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      wrPtr_q     <= '0;
      sum_q       <= '0;
      wordCount_q <= '0;
      overflow_q  <= 1'b0;
      rdValid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wrPtr_q     <= wrPtr_d;
      sum_q       <= sum_d;
      wordCount_q <= wordCount_d;
      overflow_q  <= overflow_d;
      rdValid_q   <= rdFire;
    end
  end

  // load_start overrides everything, including a handshake presented in the same cycle.
  always_comb begin
    state_d     = state_q;
    wrPtr_d     = wrPtr_q;
    sum_d       = sum_q;
    wordCount_d = wordCount_q;
    overflow_d  = overflow_q;
    accept      = 1'b0;
    if (bus.load_start) begin
      state_d     = LOAD;
      wrPtr_d     = '0;
      sum_d       = '0;
      wordCount_d = '0;
      overflow_d  = 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (bus.load_valid) begin
            accept      = 1'b1;
            wrPtr_d     = wrPtr_q + ADDR_W'(1);
            sum_d       = sum_q + bus.load_data;
            wordCount_d = wordCount_q + (ADDR_W + 1)'(1);
            if (bus.load_last) begin
              state_d = CHECK;
            end else if (&wrPtr_q) begin
              overflow_d = 1'b1;
              state_d    = ERROR;
            end
          end
        end
        CHECK:   state_d = (sum_q == bus.exp_sum) ? READY : ERROR;
        default: state_d = state_q;
      endcase
    end
  end

  assign rdFire = bus.rd_req && (state_q == READY);

  boot_mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wrEn     (accept),
    .wrAddr   (wrPtr_q),
    .wrData   (bus.load_data),
    .rdEn     (rdFire),
    .rdAddr   (bus.rd_addr),
    .rdData_q (bus.rd_data)
  );

  assign bus.load_ready = (state_q == LOAD);
  assign bus.rd_ready   = (state_q == READY);
  assign bus.boot_ok    = (state_q == READY);
  assign bus.boot_err   = (state_q == ERROR);
  assign bus.overflow   = overflow_q;
  assign bus.word_count = wordCount_q;
  assign bus.rd_valid   = rdValid_q;

  // Scan chain is stitched later; until then the hooks are tied off.
  assign unusedDft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode};
  assign scan_out0 = 1'b0;
  assign scan_out1 = 1'b0;
  assign scan_out2 = 1'b0;
  assign scan_out3 = 1'b0;
  assign scan_out4 = 1'b0;

endmodule
